fir_param_engine: RTL and testbench

Runtime-configurable FIR filter. It is the next generation of the lab FIR engine: the tap count is programmable up to a parametrised maximum, the streams support real backpressure, and the block guarantees zero history at the start of every run. Coefficients and control are accessed over AXI-Lite; samples go in and results come out over AXI-Stream. Coefficients and sample history are held in external single-port BRAMs with 1-cycle read latency.

---
 rtl/fir_param_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_fir_param_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param_engine.sv
// Runtime-configurable FIR engine. Coefficients and control live behind an
// AXI-Lite slave, samples arrive and results leave over AXI-Stream, and the
// tap coefficients and sample history sit in two external single-port BRAMs
// with one cycle of read latency. Every run starts from a zeroed history.
module fir_param_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_TAPS   = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  // AXI-Lite write
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  // AXI-Lite read
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  // AXI-Stream in
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  // AXI-Stream out
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  // Tap coefficient BRAM
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  // Sample history BRAM
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int IW = $clog2(pMAX_TAPS);
  localparam int CW = $clog2(pMAX_TAPS + 2) + 1;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_NUM  = pADDR_WIDTH'(32'h14);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h80);
  localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(128 + 4 * pMAX_TAPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_X,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic                   err_tlast_q, err_tlast_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic [pDATA_WIDTH-1:0] tap_num_q, tap_num_d;
  logic                   aw_ready_q, aw_ready_d;
  logic                   ar_ready_q, ar_ready_d;
  logic                   rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   tap_rd_pend_q, tap_rd_pend_d;
  logic                   rd_clr_q, rd_clr_d;
  logic [pDATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]          head_q, head_d;
  logic [IW-1:0]          didx_q, didx_d;
  logic [IW-1:0]          clr_q, clr_d;
  logic [CW-1:0]          mac_q, mac_d;
  logic                   rd_v_q, rd_v_d;
  logic                   prod_v_q, prod_v_d;
  logic [pDATA_WIDTH-1:0] prod_q, prod_d;
  logic [pDATA_WIDTH-1:0] acc_q, acc_d;

  logic                   wr_hs;
  logic                   ar_hs;
  logic                   in_idle;
  logic                   start_req;
  logic                   start_ok;
  logic                   last_sample;
  logic [CW-1:0]          tap_cnt;
  logic [IW-1:0]          tap_last;
  logic [pDATA_WIDTH-1:0] ctrl_word;

  function automatic logic is_tap_addr(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
  endfunction

  assign awready  = aw_ready_q;
  assign wready   = aw_ready_q;
  assign arready  = ar_ready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign sm_tdata = acc_q;

  assign wr_hs       = aw_ready_q && awvalid && wvalid;
  assign ar_hs       = ar_ready_q && arvalid;
  assign in_idle     = (state_q == S_IDLE);
  assign tap_cnt     = tap_num_q[CW-1:0];
  assign tap_last    = IW'(tap_num_q - pDATA_WIDTH'(1));
  assign last_sample = ((cnt_q + pDATA_WIDTH'(1)) == data_length_q);
  assign start_ok    = (tap_num_q != '0) && (tap_num_q <= pDATA_WIDTH'(pMAX_TAPS)) &&
                       (data_length_q != '0);
  assign ctrl_word   = pDATA_WIDTH'({err_tlast_q, 1'b0, ap_idle_q, ap_done_q, 1'b0});

  // Register file, AXI-Lite handshakes, run FSM and MAC pipeline next-state logic
  always_comb begin
    state_d       = state_q;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    err_tlast_d   = err_tlast_q;
    data_length_d = data_length_q;
    tap_num_d     = tap_num_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    tap_rd_pend_d = 1'b0;
    rd_clr_d      = rd_clr_q;
    cnt_d         = cnt_q;
    head_d        = head_q;
    didx_d        = didx_q;
    clr_d         = clr_q;
    mac_d         = mac_q;
    start_req     = 1'b0;
    tap_EN        = 1'b0;
    tap_WE        = 4'h0;
    tap_A         = '0;
    tap_Di        = '0;
    data_EN       = 1'b0;
    data_WE       = 4'h0;
    data_A        = '0;
    data_Di       = '0;
    ss_tready     = 1'b0;
    sm_tvalid     = 1'b0;
    sm_tlast      = 1'b0;

    aw_ready_d = awvalid && wvalid && !aw_ready_q;
    ar_ready_d = arvalid && !ar_ready_q && !rvalid_q && !tap_rd_pend_q && !aw_ready_d;

    rd_v_d   = 1'b0;
    prod_v_d = rd_v_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    if (rd_v_q) begin
      prod_d = tap_Do * data_Do;
    end
    if (prod_v_q) begin
      acc_d = acc_q + prod_q;
    end

    if (wr_hs) begin
      if (awaddr == ADDR_CTRL) begin
        start_req = wdata[0] && in_idle && start_ok;
      end else if (awaddr == ADDR_LEN) begin
        if (in_idle) data_length_d = wdata;
      end else if (awaddr == ADDR_NUM) begin
        if (in_idle) tap_num_d = wdata;
      end else if (is_tap_addr(awaddr) && in_idle) begin
        tap_EN = 1'b1;
        tap_WE = 4'hF;
        tap_A  = awaddr - TAP_BASE;
        tap_Di = wdata;
      end
    end

    if (ar_hs) begin
      if (is_tap_addr(araddr) && in_idle) begin
        tap_rd_pend_d = 1'b1;
        tap_EN        = 1'b1;
        tap_A         = araddr - TAP_BASE;
      end else begin
        rvalid_d = 1'b1;
        rd_clr_d = 1'b0;
        if (araddr == ADDR_CTRL) begin
          rdata_d  = ctrl_word;
          rd_clr_d = ap_done_q;
        end else if (araddr == ADDR_LEN) begin
          rdata_d = data_length_q;
        end else if (araddr == ADDR_NUM) begin
          rdata_d = tap_num_q;
        end else if (is_tap_addr(araddr)) begin
          rdata_d = '1;
        end else begin
          rdata_d = '0;
        end
      end
    end

    if (tap_rd_pend_q) begin
      rvalid_d = 1'b1;
      rdata_d  = tap_Do;
      rd_clr_d = 1'b0;
    end

    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
      rd_clr_d = 1'b0;
      if (rd_clr_q) begin
        ap_done_d   = 1'b0;
        err_tlast_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d     = S_CLEAR;
          ap_idle_d   = 1'b0;
          ap_done_d   = 1'b0;
          err_tlast_d = 1'b0;
          clr_d       = '0;
        end
      end
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'({clr_q, 2'b00});
        clr_d   = clr_q + IW'(1);
        if (clr_q == tap_last) begin
          state_d = S_WAIT_X;
          head_d  = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_WAIT_X: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = pADDR_WIDTH'({head_q, 2'b00});
          data_Di = ss_tdata;
          if (ss_tlast != last_sample) err_tlast_d = 1'b1;
          didx_d  = head_q;
          mac_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_d = mac_q + CW'(1);
        if (mac_q < tap_cnt) begin
          tap_EN  = 1'b1;
          tap_A   = pADDR_WIDTH'({mac_q[IW-1:0], 2'b00});
          data_EN = 1'b1;
          data_A  = pADDR_WIDTH'({didx_q, 2'b00});
          didx_d  = (didx_q == '0) ? tap_last : didx_q - IW'(1);
          rd_v_d  = 1'b1;
        end
        if (mac_q == tap_cnt + CW'(1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_sample;
        if (sm_tready) begin
          cnt_d = cnt_q + pDATA_WIDTH'(1);
          if (last_sample) begin
            state_d = S_DONE;
          end else begin
            head_d  = (head_q == tap_last) ? '0 : head_q + IW'(1);
            state_d = S_WAIT_X;
          end
        end
      end
      S_DONE: begin
        ap_done_d = 1'b1;
        ap_idle_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run and returns to IDLE
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q       <= S_IDLE;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      err_tlast_q   <= 1'b0;
      data_length_q <= '0;
      tap_num_q     <= '0;
      aw_ready_q    <= 1'b0;
      ar_ready_q    <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      tap_rd_pend_q <= 1'b0;
      rd_clr_q      <= 1'b0;
      cnt_q         <= '0;
      head_q        <= '0;
      didx_q        <= '0;
      clr_q         <= '0;
      mac_q         <= '0;
      rd_v_q        <= 1'b0;
      prod_v_q      <= 1'b0;
      prod_q        <= '0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      ap_done_q     <= ap_done_d;
      ap_idle_q     <= ap_idle_d;
      err_tlast_q   <= err_tlast_d;
      data_length_q <= data_length_d;
      tap_num_q     <= tap_num_d;
      aw_ready_q    <= aw_ready_d;
      ar_ready_q    <= ar_ready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      tap_rd_pend_q <= tap_rd_pend_d;
      rd_clr_q      <= rd_clr_d;
      cnt_q         <= cnt_d;
      head_q        <= head_d;
      didx_q        <= didx_d;
      clr_q         <= clr_d;
      mac_q         <= mac_d;
      rd_v_q        <= rd_v_d;
      prod_v_q      <= prod_v_d;
      prod_q        <= prod_d;
      acc_q         <= acc_d;
    end
  end

endmodule

// File: tb/tb_fir_param_engine.sv
// Self-checking bench for fir_param_engine: BRAM models, AXI-Lite tasks,
// and a scoreboard of golden FIR results compared as the output stream fires.
module tb_fir_param_engine;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MT = 32;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          awvalid, awready, wvalid, wready;
  logic [AW-1:0] awaddr;
  logic [DW-1:0] wdata;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] araddr;
  logic [DW-1:0] rdata;
  logic          ss_tvalid, ss_tready, ss_tlast;
  logic [DW-1:0] ss_tdata;
  logic          sm_tvalid, sm_tready, sm_tlast;
  logic [DW-1:0] sm_tdata;
  logic [3:0]    tap_WE, data_WE;
  logic          tap_EN, data_EN;
  logic [AW-1:0] tap_A, data_A;
  logic [DW-1:0] tap_Di, data_Di, tap_Do, data_Do;

  fir_param_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pMAX_TAPS(MT)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap coefficient BRAM: single port, one cycle read latency
  logic [DW-1:0] tapMem [MT];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (tap_WE[b]) tapMem[tap_A[6:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      end
      tap_Do <= tapMem[tap_A[6:2]];
    end
  end

  // Sample history BRAM: single port, one cycle read latency
  logic [DW-1:0] dataMem [MT];
  always @(posedge axis_clk) begin
    if (data_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (data_WE[b]) dataMem[data_A[6:2]][8*b +: 8] <= data_Di[8*b +: 8];
      end
      data_Do <= dataMem[data_A[6:2]];
    end
  end

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t expQ[$];

  logic [DW-1:0] hCoef [MT];
  logic [DW-1:0] xVec [64];
  int  nTap = 1;
  int  nLen = 1;
  bit  latChk = 1'b0;
  int  negCyc = 0;
  int  hsCyc = 0;
  bit  prevValid = 1'b0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] golden(input int n);
    logic [DW-1:0] acc;
    acc = '0;
    for (int k = 0; k < nTap; k++) begin
      if (n - k >= 0) acc = acc + hCoef[k] * xVec[n - k];
    end
    return acc;
  endfunction

  // Output monitor: compares every valid cycle against the scoreboard head,
  // pops on handshake, and measures input-to-output latency when enabled
  always @(negedge axis_clk) begin
    negCyc++;
    if (!axis_rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (ss_tvalid && ss_tready) hsCyc = negCyc;
      if (sm_tvalid) begin
        if (latChk && !prevValid) checkOutput("latency", 32'(negCyc - hsCyc), 32'(nTap + 3));
        if (expQ.size() == 0) begin
          checkOutput("sm_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("sm_tdata", sm_tdata, expQ[0].data);
          checkOutput("sm_tlast", 32'(sm_tlast), 32'(expQ[0].last));
          if (!sm_tready) checkOutput("ss_tready_stall", 32'(ss_tready), 32'd0);
          else void'(expQ.pop_front());
        end
      end
      prevValid = sm_tvalid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic axiWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit got;
    got = 1'b0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge axis_clk);
      if (awready && wready) begin got = 1'b1; break; end
    end
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (!got) checkOutput("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic axiRead(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    bit got;
    got = 1'b0;
    data = '0;
    araddr = addr; arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge axis_clk);
      if (arready) begin got = 1'b1; break; end
    end
    @(posedge axis_clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    if (!got) checkOutput("ar_timeout", 32'd0, 32'd1);
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge axis_clk);
      if (rvalid) begin got = 1'b1; data = rdata; break; end
    end
    @(posedge axis_clk); #1;
    rready = 1'b0;
    if (!got) checkOutput("r_timeout", 32'd0, 32'd1);
  endtask

  task automatic readCheck(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    logic [DW-1:0] v;
    axiRead(addr, v);
    checkOutput(tag, v, exp);
  endtask

  task automatic configure();
    axiWrite(12'h014, 32'(nTap));
    axiWrite(12'h010, 32'(nLen));
    for (int k = 0; k < nTap; k++) axiWrite(AW'(12'h080 + 4 * k), hCoef[k]);
  endtask

  // Drives nLen samples, pushing each golden result before its handshake.
  // stallAfter: hold sm_tready low for 20 cycles after that sample.
  // probeBusy: exercise the register file while the run is in progress.
  task automatic applyStimulus(input bit badLast, input int stallAfter, input bit probeBusy);
    bit got;
    exp_t e;
    for (int i = 0; i < nLen; i++) begin
      e.data = golden(i);
      e.last = (i == nLen - 1);
      expQ.push_back(e);
      ss_tdata  = xVec[i];
      ss_tlast  = (i == nLen - 1) ^ badLast;
      ss_tvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 500; t++) begin
        @(negedge axis_clk);
        if (ss_tready) begin got = 1'b1; break; end
      end
      @(posedge axis_clk); #1;
      ss_tvalid = 1'b0;
      if (!got) checkOutput("ss_timeout", 32'd0, 32'd1);
      if (i == stallAfter) begin
        sm_tready = 1'b0;
        repeat (20) @(posedge axis_clk);
        #1 sm_tready = 1'b1;
      end
      if (probeBusy && i == 0) begin
        axiWrite(12'h000, 32'd1);
        readCheck("busy_tap_read", 12'h080, 32'hFFFF_FFFF);
        readCheck("busy_ctrl", 12'h000, 32'h0);
        axiWrite(12'h014, 32'd7);
        axiWrite(12'h010, 32'd9);
        axiWrite(12'h084, 32'd99);
      end
    end
  endtask

  task automatic waitDone(input logic [DW-1:0] expCtrl);
    logic [DW-1:0] v;
    bit got;
    got = 1'b0;
    v = '0;
    for (int t = 0; t < 200; t++) begin
      axiRead(12'h000, v);
      if (v[2]) begin got = 1'b1; break; end
    end
    if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    else checkOutput("ap_ctrl_done", v, expCtrl);
    readCheck("ap_ctrl_after", 12'h000, 32'h4);
    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic runFilter(input bit badLast, input int stallAfter, input bit probeBusy,
                           input logic [DW-1:0] expCtrl);
    axiWrite(12'h000, 32'd1);
    applyStimulus(badLast, stallAfter, probeBusy);
    waitDone(expCtrl);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awready"}, 32'(awready), 32'd0);
    checkOutput({tag, "_arready"}, 32'(arready), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_ss_tready"}, 32'(ss_tready), 32'd0);
    checkOutput({tag, "_sm_tvalid"}, 32'(sm_tvalid), 32'd0);
    checkOutput({tag, "_sm_tdata"}, sm_tdata, 32'd0);
    checkOutput({tag, "_we"}, 32'({tap_WE, data_WE}), 32'd0);
  endtask

  task automatic setTest1();
    nTap = 3; nLen = 4;
    hCoef[0] = 32'd1; hCoef[1] = 32'd2; hCoef[2] = 32'd3;
    for (int i = 0; i < 4; i++) xVec[i] = 32'd1;
  endtask

  initial begin
    awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
    arvalid = 0; araddr = '0; rready = 0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 1'b1;

    // Power-on reset
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    checkResetOutputs("por");
    @(posedge axis_clk); #1 axis_rst_n = 1'b1;
    readCheck("rst_ctrl", 12'h000, 32'h4);
    readCheck("rst_len", 12'h010, 32'h0);
    readCheck("rst_tapnum", 12'h014, 32'h0);
    readCheck("unmapped", 12'h020, 32'h0);

    // Basic run, plus tap readback through the BRAM while idle
    setTest1();
    configure();
    readCheck("tap1_readback", 12'h084, 32'd2);
    runFilter(1'b0, -1, 1'b0, 32'h6);

    // Impulse through 11 taps with latency measurement
    nTap = 11; nLen = 11;
    for (int k = 0; k < 11; k++) hCoef[k] = 32'(k);
    for (int i = 0; i < 11; i++) xVec[i] = (i == 0) ? 32'd1 : 32'd0;
    configure();
    latChk = 1'b1;
    runFilter(1'b0, -1, 1'b0, 32'h6);
    latChk = 1'b0;

    // Output backpressure mid-run with signed data
    nTap = 3; nLen = 6;
    hCoef[0] = 32'd3; hCoef[1] = 32'hFFFF_FFFF; hCoef[2] = 32'd2;
    xVec[0] = 32'd7; xVec[1] = 32'hFFFF_FFFD; xVec[2] = 32'd10;
    xVec[3] = 32'd2; xVec[4] = 32'hFFFF_FFF8; xVec[5] = 32'd5;
    configure();
    runFilter(1'b0, 2, 1'b0, 32'h6);

    // History is cleared between runs
    nTap = 2; nLen = 2;
    hCoef[0] = 32'd1; hCoef[1] = 32'd1;
    xVec[0] = 32'd5; xVec[1] = 32'd5;
    configure();
    runFilter(1'b0, -1, 1'b0, 32'h6);
    nLen = 1; xVec[0] = 32'd1;
    configure();
    runFilter(1'b0, -1, 1'b0, 32'h6);

    // Negative coefficient, wrong tlast on the only sample
    nTap = 1; nLen = 1;
    hCoef[0] = 32'hFFFF_FFFE; xVec[0] = 32'd3;
    checkOutput("neg_golden", golden(0), 32'hFFFF_FFFA);
    configure();
    runFilter(1'b1, -1, 1'b0, 32'h16);

    // Register access while busy is ignored or masked
    nTap = 2; nLen = 3;
    hCoef[0] = 32'd1; hCoef[1] = 32'd1;
    xVec[0] = 32'd2; xVec[1] = 32'd4; xVec[2] = 32'd6;
    configure();
    runFilter(1'b0, -1, 1'b1, 32'h6);
    readCheck("busy_tapnum_kept", 12'h014, 32'd2);
    readCheck("busy_len_kept", 12'h010, 32'd3);
    readCheck("busy_tap_kept", 12'h084, 32'd1);

    // Illegal tap counts refuse to start
    axiWrite(12'h014, 32'd0);
    axiWrite(12'h000, 32'd1);
    repeat (3) @(posedge axis_clk); #1;
    readCheck("start_tap0", 12'h000, 32'h4);
    axiWrite(12'h014, 32'd33);
    axiWrite(12'h000, 32'd1);
    repeat (3) @(posedge axis_clk); #1;
    readCheck("start_tap33", 12'h000, 32'h4);

    // Reset during MAC aborts the run
    nTap = 11; nLen = 11;
    for (int k = 0; k < 11; k++) hCoef[k] = 32'(k);
    for (int i = 0; i < 11; i++) xVec[i] = (i == 0) ? 32'd1 : 32'd0;
    configure();
    axiWrite(12'h000, 32'd1);
    nLen = 1;
    applyStimulus(1'b0, -1, 1'b0);
    repeat (3) @(posedge axis_clk);
    #1 axis_rst_n = 1'b0;
    @(negedge axis_clk);
    checkResetOutputs("midrun");
    expQ.delete();
    @(posedge axis_clk); #1 axis_rst_n = 1'b1;
    readCheck("midrun_ctrl", 12'h000, 32'h4);
    readCheck("midrun_tapnum", 12'h014, 32'h0);
    setTest1();
    configure();
    runFilter(1'b0, -1, 1'b0, 32'h6);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
